// File: rtl/main_fifo_reader.sv
// Read-side controller for the main FIFO: pops words, routes each to VC0/VC1 by a
// destination bit, parks one word in a hold register under pause back-pressure.
module main_fifo_reader #(
    parameter int DATA_W       = 6,
    parameter int DEST_BIT     = 4,
    parameter int HOLD_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_data,
    input  logic [1:0]        pause,
    output logic              fifo_rd,
    output logic [1:0]        push,
    output logic [DATA_W-1:0] data_out,
    output logic [7:0]        fwd_count,
    output logic              stall_err
);

    localparam int CNT_W = $clog2(HOLD_TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

    state_t            state;
    logic              ret_valid;
    logic [DATA_W-1:0] hold_data;
    logic [CNT_W-1:0]  hold_cnt;
    logic              ret_dest;
    logic              hold_dest;
    logic              blocked;

    assign ret_dest  = fifo_data[DEST_BIT];
    assign hold_dest = hold_data[DEST_BIT];
    assign blocked   = ret_valid & pause[ret_dest];

    // Gating on blocked guarantees no second word is in flight when HOLD is entered.
    assign fifo_rd = (state == RUN) & enable & ~fifo_empty & ~blocked;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            ret_valid <= 1'b0;
            hold_data <= '0;
            hold_cnt  <= '0;
            push      <= 2'b00;
            data_out  <= '0;
            fwd_count <= 8'd0;
            stall_err <= 1'b0;
        end else begin
            ret_valid <= fifo_rd;
            push      <= 2'b00;
            case (state)
                IDLE: begin
                    if (enable)
                        state <= RUN;
                end
                RUN: begin
                    if (blocked) begin
                        hold_data <= fifo_data;
                        hold_cnt  <= '0;
                        state     <= HOLD;
                    end else begin
                        if (ret_valid) begin
                            push[ret_dest] <= 1'b1;
                            data_out       <= fifo_data;
                            fwd_count      <= fwd_count + 8'd1;
                        end
                        if (!enable)
                            state <= IDLE;
                    end
                end
                HOLD: begin
                    if (!pause[hold_dest]) begin
                        push[hold_dest] <= 1'b1;
                        data_out        <= hold_data;
                        fwd_count       <= fwd_count + 8'd1;
                        hold_cnt        <= '0;
                        state           <= enable ? RUN : IDLE;
                    end else if (hold_cnt != CNT_W'(HOLD_TIMEOUT)) begin
                        // Counter saturates at the timeout; the error flag stays sticky.
                        hold_cnt <= hold_cnt + 1'b1;
                        if (hold_cnt == CNT_W'(HOLD_TIMEOUT - 1))
                            stall_err <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_main_fifo_reader.sv
// Bench for main_fifo_reader: a FIFO model feeds directed words, a scoreboard queue
// holds the expected push per popped word, and a monitor compares every push.
module tb_main_fifo_reader;

    typedef struct {
        logic [1:0] push;
        logic [5:0] data;
    } exp_t;

    logic       clk;
    logic       reset;
    logic       enable;
    logic       fifo_empty;
    logic [5:0] fifo_data;
    logic [1:0] pause;
    logic       fifo_rd;
    logic [1:0] push;
    logic [5:0] data_out;
    logic [7:0] fwd_count;
    logic       stall_err;

    logic [5:0] fifo_q[$];
    exp_t       exp_q[$];
    exp_t       mon_exp;
    int         checks     = 0;
    int         errors     = 0;
    int         push_seen  = 0;
    int         rd_count   = 0;
    int         cyc        = 0;
    int         first_rd   = -1;
    int         last_rd    = -1;
    int         rd_mark;
    int         push_mark;

    main_fifo_reader dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .pause      (pause),
        .fifo_rd    (fifo_rd),
        .push       (push),
        .data_out   (data_out),
        .fwd_count  (fwd_count),
        .stall_err  (stall_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: every push must match the oldest outstanding expected word.
    always @(negedge clk) begin
        if (push != 2'b00) begin
            push_seen++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_push got push=%b data=%h, required no push", push, data_out);
            end else begin
                mon_exp = exp_q.pop_front();
                if (push !== mon_exp.push || data_out !== mon_exp.data) begin
                    errors++;
                    $display("[TB] FAIL push_word got push=%b data=%h, required push=%b data=%h",
                             push, data_out, mon_exp.push, mon_exp.data);
                end
            end
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s got %0d, required %0d", name, actual, expected);
        end
    endtask

    task automatic load_word(input logic [5:0] w);
        fifo_q.push_back(w);
        fifo_empty = 1'b0;
    endtask

    // One clock: inputs change at the falling edge, the FIFO model pops on the rising edge.
    task automatic cycle(input logic rst, input logic en, input logic [1:0] p);
        logic       rd;
        logic [5:0] w;
        w = 6'd0;
        @(negedge clk);
        reset  = rst;
        enable = en;
        pause  = p;
        #1;
        rd = fifo_rd;
        if (rd) begin
            w = fifo_q.pop_front();
            rd_count++;
            if (first_rd < 0) first_rd = cyc;
            last_rd = cyc;
            if (rst) exp_q.push_back('{push: 2'b01 << w[4], data: w});
        end
        if (!rst) exp_q.delete();
        @(posedge clk);
        #1;
        if (rd) fifo_data = w;
        fifo_empty = (fifo_q.size() == 0);
        cyc++;
    endtask

    task automatic applyStimulus(input logic rst, input logic en, input logic [1:0] p, input int n);
        for (int i = 0; i < n; i++) cycle(rst, en, p);
    endtask

    initial begin
        reset      = 1'b0;
        enable     = 1'b0;
        pause      = 2'b00;
        fifo_empty = 1'b1;
        fifo_data  = 6'd0;

        applyStimulus(1'b0, 1'b0, 2'b00, 2);
        checkOutput("reset_push", int'(push), 0);
        checkOutput("reset_data_out", int'(data_out), 0);
        checkOutput("reset_fwd_count", int'(fwd_count), 0);
        checkOutput("reset_stall_err", int'(stall_err), 0);
        checkOutput("reset_fifo_rd", int'(fifo_rd), 0);

        // Three back-to-back words to alternating destinations.
        load_word(6'h05);
        load_word(6'h13);
        load_word(6'h21);
        applyStimulus(1'b1, 1'b1, 2'b00, 8);
        checkOutput("burst_rd_count", rd_count, 3);
        checkOutput("burst_rd_consecutive", last_rd - first_rd, 2);
        checkOutput("burst_fwd_count", int'(fwd_count), 3);

        // Word for VC1 returns while VC1 paused; a second word must wait behind it.
        load_word(6'h12);
        load_word(6'h03);
        rd_mark = rd_count;
        applyStimulus(1'b1, 1'b1, 2'b10, 6);
        checkOutput("hold_no_pop", rd_count - rd_mark, 1);
        checkOutput("hold_fwd_count", int'(fwd_count), 3);
        checkOutput("hold_stall_err", int'(stall_err), 0);
        applyStimulus(1'b1, 1'b1, 2'b00, 5);
        checkOutput("release_fwd_count", int'(fwd_count), 5);
        checkOutput("release_stall_err", int'(stall_err), 0);

        // Prolonged pause on a held word raises the sticky stall error.
        load_word(6'h15);
        applyStimulus(1'b1, 1'b1, 2'b10, 20);
        checkOutput("stall_err_set", int'(stall_err), 1);
        checkOutput("stall_fwd_count", int'(fwd_count), 5);
        applyStimulus(1'b1, 1'b1, 2'b00, 3);
        checkOutput("stall_err_sticky", int'(stall_err), 1);
        checkOutput("stall_delivered", int'(fwd_count), 6);

        // Enable dropped the cycle after a pop: that word finishes, nothing else pops.
        load_word(6'h0A);
        load_word(6'h0B);
        rd_mark = rd_count;
        applyStimulus(1'b1, 1'b1, 2'b00, 1);
        applyStimulus(1'b1, 1'b0, 2'b00, 5);
        checkOutput("disable_single_pop", rd_count - rd_mark, 1);
        checkOutput("disable_fwd_count", int'(fwd_count), 7);
        applyStimulus(1'b1, 1'b1, 2'b00, 5);
        checkOutput("reenable_fwd_count", int'(fwd_count), 8);

        // Reset while a word is held: the word is lost and everything clears.
        load_word(6'h1F);
        applyStimulus(1'b1, 1'b1, 2'b10, 5);
        push_mark = push_seen;
        applyStimulus(1'b0, 1'b1, 2'b10, 1);
        checkOutput("hold_reset_push", int'(push), 0);
        checkOutput("hold_reset_data_out", int'(data_out), 0);
        checkOutput("hold_reset_fwd_count", int'(fwd_count), 0);
        checkOutput("hold_reset_stall_err", int'(stall_err), 0);
        checkOutput("hold_reset_fifo_rd", int'(fifo_rd), 0);
        applyStimulus(1'b1, 1'b1, 2'b00, 4);
        checkOutput("held_word_lost", push_seen - push_mark, 0);

        // 256 words stream through; the forwarded count wraps back to zero.
        for (int i = 0; i < 256; i++) load_word(6'(i));
        rd_mark   = rd_count;
        push_mark = push_seen;
        applyStimulus(1'b1, 1'b1, 2'b00, 262);
        checkOutput("wrap_rd_count", rd_count - rd_mark, 256);
        checkOutput("wrap_push_count", push_seen - push_mark, 256);
        checkOutput("wrap_fwd_count", int'(fwd_count), 0);

        checkOutput("scoreboard_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
